write_arbiter: RTL and testbench
================================

# write_arbiter

Collects completed results from the execution units (ALU, FPU, load unit, branch/link) and serialises them into the single register write-back stream consumed by the register manager as `w_write_d_r` {order, pa_rd, data}. Each source gets a 2-entry buffer with valid/ready handshake. A round-robin arbiter issues at most one write per cycle. Buffered and in-flight results belonging to a squashed branch context are discarded on `branch_hazard`.

## Interface
- `NUM_SRC`, 4: number of execution-unit result ports, range 2..8.
- `LEN_CONTEXT`, `LEN_CONTEXT`: branch-context bitmask width, one-hot per speculative branch level.
- `LEN_PREG_ADDR`, 6: physical register address width.
- `LEN_WORD`, 32: data width.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `src_valid`  in  NUM_SRC: per-source result valid.
- `src_ready`  out  NUM_SRC: per-source buffer can accept.
- `src_pa_rd`  in  NUM_SRC*LEN_PREG_ADDR: packed destination register, source i at slice i.
- `src_data`  in  NUM_SRC*LEN_WORD: packed result data.
- `src_context`  in  NUM_SRC*LEN_CONTEXT: packed context mask of the producing instruction.
- `branch_hazard`  in  1: misprediction flush strobe, single cycle.
- `hazard_context_info`  in  LEN_CONTEXT: contexts being squashed.
- `w_write_d_r`  out  1+LEN_PREG_ADDR+LEN_WORD: {order, pa_rd, data}, order in the MSB.

## Operation
- Transfer on source i when `src_valid[i] & src_ready[i]`.
- `src_ready[i]` is registered-derived: high when the slot count is below 2. It does not depend on `src_valid`.
- Input drop (accepted, never buffered) when either holds:
  - `pa_rd == 0`;
  - `branch_hazard & |(src_context & hazard_context_info)` in the same cycle.
- Per-source slot: 2-entry FIFO holding {pa_rd, data, context}. Count is 0..2. Pointers wrap mod 2.
- Arbiter:
  - Candidates are slots whose head entry is valid and not squashed this cycle.
  - Round-robin pointer `rr`, reset 0. Grant goes to the first candidate at or after `rr`, wrapping.
  - After a grant to source g, `rr <= (g+1) mod NUM_SRC`. With no grant, `rr` holds.
- Output register {out_valid, out_pa, out_data, out_ctx}, loaded each cycle with the granted head; out_valid is 0 if no grant.
- `order = out_valid & ~(branch_hazard & |(out_ctx & hazard_context_info))`. A squashed output is never written.
- Flush: on `branch_hazard`, every slot entry whose context intersects `hazard_context_info` is invalidated at the edge. Entries are compacted so that survivors keep their order.
- Simultaneous enqueue and dequeue on one slot: count unchanged. An enqueue at count 2 with a same-cycle dequeue is not allowed, because ready was low.
- Reset: all slots empty, `src_ready` all 1 on the cycle after reset, out_valid 0, `w_write_d_r` all zero, `rr` 0.

## Timing
- Latency: a result accepted at edge t0 can be granted in cycle t0..t1 and appears on `w_write_d_r` after edge t1. Minimum is 2 edges from accept to visible write.
- Throughput: 1 write per cycle aggregate, and 1 accept per source per cycle.
- `src_ready` deasserts the cycle after the slot reaches 2 and reasserts the cycle after a dequeue.
- A hazard asserted in cycle c affects the combinational order in cycle c. Slot and output state are clean from edge c+1.
- `rst` mid-operation discards all buffered results without emitting them.

## Configuration
- `WRITE_ARB_FIXED_PRIO_EN`:
  - Defined: the arbiter is fixed priority (lowest index wins) and `rr` is removed. Used when the load unit is placed on index 0 to minimise load-use latency.
  - Undefined: round-robin as specified above.

## Structure
- Shared package/include:
  - `LEN_WRITE_D_R`.
  - The {order, pa_rd, data} packing, reusing the existing write_d_r pack/unpack structs.
  - `CONTEXT_ZERO`.
  - A helper for the hazard-match predicate.
- Sub-module `write_arbiter_slot`: 2-entry FIFO with context-flush compaction, exposing head, head_valid, count and ready. Instantiated `NUM_SRC` times in a generate loop.

## Test plan
- Single source, src0 writes pa 5 data 0xDEADBEEF ctx 0 -> after 2 edges, `w_write_d_r` = {1, 5, 0xDEADBEEF} for exactly one cycle.
- All 4 sources valid every cycle with distinct pa 1..4, round-robin -> grants 0,1,2,3,0,…. Each source's `src_ready` settles to a 1-accept-per-4-cycles pattern with no drop or duplicate.
- src2 holds 2 entries ctx 0b01 and 0b10, `branch_hazard`=1 with info 0b01 -> only the 0b10 entry is emitted later; any 0b01 output in that cycle has order 0.
- Write to pa 0 with data 0x1234 -> accepted (ready stays 1), no write ever issued.
- Fill src1 to count 2 with no grant possible (other sources hog under `WRITE_ARB_FIXED_PRIO_EN`, src0 continuous) -> `src_ready[1]`=0, and src1 is starved until src0 idles.
- Assert `rst` with 5 buffered entries -> next cycle `w_write_d_r`=0, all `src_ready`=1, nothing emitted afterwards.

Source files
------------

// File: rtl/write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// write_arbiter_pkg
// Shared definitions for the write-back arbiter:
//   - default field widths and LEN_WRITE_D_R (width of {order, pa_rd, data})
//   - write_d_r_t pack/unpack struct for the register-manager write stream
//   - CONTEXT_ZERO, the empty branch-context mask
//   - hazard_hit(), the "this context is being squashed now" predicate
// -----------------------------------------------------------------------------
package write_arbiter_pkg;

  localparam int LEN_CONTEXT_DEF   = 4;
  localparam int LEN_PREG_ADDR_DEF = 6;
  localparam int LEN_WORD_DEF      = 32;
  localparam int LEN_WRITE_D_R     = 1 + LEN_PREG_ADDR_DEF + LEN_WORD_DEF;

  // Widest context mask the hazard helper handles; callers widen to this.
  localparam int CTX_W_MAX = 32;

  localparam logic [LEN_CONTEXT_DEF-1:0] CONTEXT_ZERO = '0;

  // Write-back word as seen by the register manager, order in the MSB.
  typedef struct packed {
    logic                         order;
    logic [LEN_PREG_ADDR_DEF-1:0] pa_rd;
    logic [LEN_WORD_DEF-1:0]      data;
  } write_d_r_t;

  function automatic logic [LEN_WRITE_D_R-1:0] pack_write_d_r(input write_d_r_t w);
    return w;
  endfunction

  function automatic write_d_r_t unpack_write_d_r(input logic [LEN_WRITE_D_R-1:0] v);
    return v;
  endfunction

  // True when a flush is active and the entry belongs to a squashed context.
  function automatic logic hazard_hit(input logic                 hazard,
                                      input logic [CTX_W_MAX-1:0] ctx,
                                      input logic [CTX_W_MAX-1:0] info);
    return hazard & (|(ctx & info));
  endfunction

endpackage

// File: rtl/write_arbiter_slot.sv
// -----------------------------------------------------------------------------
// write_arbiter_slot
// Two-entry in-order buffer for one execution-unit result port. Entries hold
// {pa_rd, data, context}. On a flush, entries of squashed contexts are removed
// at the clock edge and the survivors are compacted towards the head so their
// order is preserved.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enq_i, enq_*_i      push one entry (caller guarantees room)
//   deq_i               pop the head (caller guarantees head is valid/unsquashed)
//   flush_i, flush_ctx_i branch hazard strobe and contexts being squashed
//   head_*_o            head entry fields
//   head_valid_o        head entry present
//   count_o             occupancy 0..2
//   ready_o             room for another entry (count < 2), purely registered
// -----------------------------------------------------------------------------
module write_arbiter_slot
  import write_arbiter_pkg::*;
#(
  parameter int LEN_PREG_ADDR = LEN_PREG_ADDR_DEF,
  parameter int LEN_WORD      = LEN_WORD_DEF,
  parameter int LEN_CONTEXT   = LEN_CONTEXT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_i,
  input  logic [LEN_PREG_ADDR-1:0] enq_pa_i,
  input  logic [LEN_WORD-1:0]      enq_data_i,
  input  logic [LEN_CONTEXT-1:0]   enq_ctx_i,
  input  logic                     deq_i,
  input  logic                     flush_i,
  input  logic [LEN_CONTEXT-1:0]   flush_ctx_i,
  output logic [LEN_PREG_ADDR-1:0] head_pa_o,
  output logic [LEN_WORD-1:0]      head_data_o,
  output logic [LEN_CONTEXT-1:0]   head_ctx_o,
  output logic                     head_valid_o,
  output logic [1:0]               count_o,
  output logic                     ready_o
);

  localparam int ENT_W = LEN_PREG_ADDR + LEN_WORD + LEN_CONTEXT;

  // Entry 0 is always the head; entry 1 is only meaningful at count 2.
  logic [ENT_W-1:0] ent_q [2];
  logic [ENT_W-1:0] ent_d [2];
  logic [1:0]       count_q, count_d;
  logic             hit0, hit1, keep0, keep1;

  assign hit0 = hazard_hit(flush_i, CTX_W_MAX'(ent_q[0][LEN_CONTEXT-1:0]),
                           CTX_W_MAX'(flush_ctx_i));
  assign hit1 = hazard_hit(flush_i, CTX_W_MAX'(ent_q[1][LEN_CONTEXT-1:0]),
                           CTX_W_MAX'(flush_ctx_i));

  assign keep0 = (count_q != 2'd0) & ~deq_i & ~hit0;
  assign keep1 = (count_q == 2'd2) & ~hit1;

  // Rebuild the queue from survivors in age order, then append the new entry.
  always_comb begin : p_next
    logic [1:0] fill;
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    fill     = 2'd0;
    if (keep0) begin
      ent_d[0] = ent_q[0];
      fill     = 2'd1;
    end
    if (keep1) begin
      ent_d[fill[0]] = ent_q[1];
      fill           = fill + 2'd1;
    end
    if (enq_i && (fill != 2'd2)) begin
      ent_d[fill[0]] = {enq_pa_i, enq_data_i, enq_ctx_i};
      fill           = fill + 2'd1;
    end
    count_d = fill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
    ent_q[0] <= ent_d[0];
    ent_q[1] <= ent_d[1];
  end

  assign head_pa_o    = ent_q[0][ENT_W-1 -: LEN_PREG_ADDR];
  assign head_data_o  = ent_q[0][LEN_CONTEXT +: LEN_WORD];
  assign head_ctx_o   = ent_q[0][LEN_CONTEXT-1:0];
  assign head_valid_o = (count_q != 2'd0);
  assign count_o      = count_q;
  assign ready_o      = (count_q != 2'd2);

endmodule

// File: rtl/write_arbiter.sv
// -----------------------------------------------------------------------------
// write_arbiter
// Merges completed results from NUM_SRC execution units into one register
// write-back stream {order, pa_rd, data}. Each source has a 2-entry slot;
// an arbiter picks one head per cycle into an output register. Results of
// squashed branch contexts are dropped on input, flushed from the slots, and
// masked on the output (order forced low) in the hazard cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   src_valid/src_ready   per-source handshake (ready is registered-derived)
//   src_pa_rd/src_data/src_context  packed per-source fields, source i at slice i
//   branch_hazard, hazard_context_info  single-cycle flush and squashed contexts
//   w_write_d_r           {order, pa_rd, data}
// Configuration macro:
//   WRITE_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest index wins, no
//                            round-robin pointer. Undefined: round-robin.
// -----------------------------------------------------------------------------
module write_arbiter
  import write_arbiter_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int LEN_CONTEXT   = LEN_CONTEXT_DEF,
  parameter int LEN_PREG_ADDR = LEN_PREG_ADDR_DEF,
  parameter int LEN_WORD      = LEN_WORD_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SRC-1:0]               src_valid,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic [NUM_SRC*LEN_PREG_ADDR-1:0] src_pa_rd,
  input  logic [NUM_SRC*LEN_WORD-1:0]      src_data,
  input  logic [NUM_SRC*LEN_CONTEXT-1:0]   src_context,
  input  logic                             branch_hazard,
  input  logic [LEN_CONTEXT-1:0]           hazard_context_info,
  output logic [LEN_PREG_ADDR+LEN_WORD:0]  w_write_d_r
);

  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]       enq, deq, cand, head_valid;
  logic [LEN_PREG_ADDR-1:0] head_pa   [NUM_SRC];
  logic [LEN_WORD-1:0]      head_data [NUM_SRC];
  logic [LEN_CONTEXT-1:0]   head_ctx  [NUM_SRC];

  logic             grant_valid;
  logic [SRC_W-1:0] grant_idx;

  logic                     out_valid_q, out_valid_d;
  logic [LEN_PREG_ADDR-1:0] out_pa_q, out_pa_d;
  logic [LEN_WORD-1:0]      out_data_q, out_data_d;
  logic [LEN_CONTEXT-1:0]   out_ctx_q, out_ctx_d;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [LEN_PREG_ADDR-1:0] in_pa;
    logic [LEN_WORD-1:0]      in_data;
    logic [LEN_CONTEXT-1:0]   in_ctx;
    logic [1:0]               count;
    logic                     drop;

    assign in_pa   = src_pa_rd[gi*LEN_PREG_ADDR +: LEN_PREG_ADDR];
    assign in_data = src_data[gi*LEN_WORD +: LEN_WORD];
    assign in_ctx  = src_context[gi*LEN_CONTEXT +: LEN_CONTEXT];

    // Writes to pa 0 and results already squashed are accepted but never stored.
    assign drop = (in_pa == '0) |
                  hazard_hit(branch_hazard, CTX_W_MAX'(in_ctx), CTX_W_MAX'(hazard_context_info));

    // Accept only while the slot has room.
    assign enq[gi] = src_valid[gi] & (count != 2'd2) & ~drop;

    // A head being squashed this cycle must not win the arbiter.
    assign cand[gi] = head_valid[gi] &
                      ~hazard_hit(branch_hazard, CTX_W_MAX'(head_ctx[gi]),
                                  CTX_W_MAX'(hazard_context_info));

    assign deq[gi] = grant_valid & (grant_idx == SRC_W'(gi));

    write_arbiter_slot #(
      .LEN_PREG_ADDR (LEN_PREG_ADDR),
      .LEN_WORD      (LEN_WORD),
      .LEN_CONTEXT   (LEN_CONTEXT)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .enq_i        (enq[gi]),
      .enq_pa_i     (in_pa),
      .enq_data_i   (in_data),
      .enq_ctx_i    (in_ctx),
      .deq_i        (deq[gi]),
      .flush_i      (branch_hazard),
      .flush_ctx_i  (hazard_context_info),
      .head_pa_o    (head_pa[gi]),
      .head_data_o  (head_data[gi]),
      .head_ctx_o   (head_ctx[gi]),
      .head_valid_o (head_valid[gi]),
      .count_o      (count),
      .ready_o      (src_ready[gi])
    );
  end

`ifdef WRITE_ARB_FIXED_PRIO_EN
  // Lowest index wins: scan downwards so the last assignment is the lowest.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (cand[k]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(k);
      end
    end
  end
`else
  logic [SRC_W-1:0] rr_q, rr_d;

  // First candidate at or after rr, wrapping around.
  always_comb begin : p_arb
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      if (!grant_valid && cand[SRC_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_valid) begin
      rr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Idle cycles load zeros so the write stream reads all-zero when nothing issues.
  always_comb begin
    out_valid_d = grant_valid;
    out_pa_d    = '0;
    out_data_d  = '0;
    out_ctx_d   = LEN_CONTEXT'(CONTEXT_ZERO);
    if (grant_valid) begin
      out_pa_d   = head_pa[grant_idx];
      out_data_d = head_data[grant_idx];
      out_ctx_d  = head_ctx[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pa_q    <= '0;
      out_data_q  <= '0;
      out_ctx_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pa_q    <= out_pa_d;
      out_data_q  <= out_data_d;
      out_ctx_q   <= out_ctx_d;
    end
  end

  // The output register can still hold a result whose context is squashed in
  // this very cycle; masking order keeps it from being written.
  assign w_write_d_r = {out_valid_q &
                        ~hazard_hit(branch_hazard, CTX_W_MAX'(out_ctx_q),
                                    CTX_W_MAX'(hazard_context_info)),
                        out_pa_q, out_data_q};

endmodule

// File: tb/tb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_write_arbiter
// Directed self-checking bench for write_arbiter (default 4 sources, 4-bit
// context, 6-bit pa, 32-bit data). Expected write words are hand-derived.
// -----------------------------------------------------------------------------
module tb_write_arbiter;
  import write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic [23:0] src_pa_rd;
  logic [127:0] src_data;
  logic [15:0] src_context;
  logic        branch_hazard;
  logic [3:0]  hazard_context_info;
  logic [38:0] w_write_d_r;

  int n_tests = 0;
  int n_fail  = 0;

  write_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .src_valid           (src_valid),
    .src_ready           (src_ready),
    .src_pa_rd           (src_pa_rd),
    .src_data            (src_data),
    .src_context         (src_context),
    .branch_hazard       (branch_hazard),
    .hazard_context_info (hazard_context_info),
    .w_write_d_r         (w_write_d_r)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %h", tag, got);
    end
  endtask

  function automatic logic [63:0] wr(input logic o, input logic [5:0] pa, input logic [31:0] d);
    write_d_r_t s;
    s.order = o;
    s.pa_rd = pa;
    s.data  = d;
    return 64'(pack_write_d_r(s));
  endfunction

  task automatic set_src(input int i, input logic [5:0] pa, input logic [31:0] d,
                         input logic [3:0] ctx);
    src_pa_rd[i*6 +: 6]    = pa;
    src_data[i*32 +: 32]   = d;
    src_context[i*4 +: 4]  = ctx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    src_valid           = '0;
    src_pa_rd           = '0;
    src_data            = '0;
    src_context         = '0;
    branch_hazard       = 1'b0;
    hazard_context_info = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] fire;
    logic [3:0] exp_rdy;
    logic [4:0] lg;
    int kcnt [4];
    int n, s, kk;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_state_w", 64'(w_write_d_r), 64'd0);
    check("rst_state_rdy", 64'(src_ready), 64'hF);

    // ---------------- single source, 2-edge latency ----------------
    set_src(0, 6'd5, 32'hDEADBEEF, 4'b0000);
    src_valid = 4'b0001;
    tick();
    src_valid = 4'b0000;
    check("single_e1", 64'(w_write_d_r), 64'd0);
    tick();
    check("single_e2", 64'(w_write_d_r), wr(1'b1, 6'd5, 32'hDEADBEEF));
    tick();
    check("single_e3", 64'(w_write_d_r), 64'd0);

`ifndef WRITE_ARB_FIXED_PRIO_EN
    // ---------------- round-robin, all sources continuous ----------------
    // Output after edge m is source (m-2)%4's ((m-2)/4)-th accepted result,
    // and ready is one-hot at bit (m-2)%4.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      kcnt[i] = 0;
      set_src(i, 6'(i + 1), 32'hA000_0000 | 32'(i << 8), 4'b0000);
    end
    src_valid = 4'b1111;
    for (int m = 1; m <= 13; m++) begin
      fire = src_valid & src_ready;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (fire[i]) begin
          kcnt[i]++;
          set_src(i, 6'(i + 1), 32'hA000_0000 | 32'(i << 8) | 32'(kcnt[i]), 4'b0000);
        end
      end
      if (m >= 2) begin
        n  = m - 2;
        s  = n % 4;
        kk = n / 4;
        check("rr_out", 64'(w_write_d_r),
              wr(1'b1, 6'(s + 1), 32'hA000_0000 | 32'(s << 8) | 32'(kk)));
        exp_rdy = 4'b0001 << s;
        check("rr_ready", 64'(src_ready), 64'(exp_rdy));
      end
    end
    src_valid = 4'b0000;
`else
    // ---------------- fixed priority: src0 hogs, src1 starves ----------------
    do_reset();
    kcnt[0] = 0;
    set_src(0, 6'd1, 32'hF000_0000, 4'b0000);
    set_src(1, 6'd2, 32'h2200_0000, 4'b0000);
    src_valid = 4'b0011;
    for (int m = 1; m <= 6; m++) begin
      fire = src_valid & src_ready;
      tick();
      if (fire[0]) begin
        kcnt[0]++;
        set_src(0, 6'd1, 32'hF000_0000 | 32'(kcnt[0]), 4'b0000);
      end
      if (m >= 2) begin
        check("fp_out", 64'(w_write_d_r), wr(1'b1, 6'd1, 32'hF000_0000 | 32'(m - 2)));
        check("fp_rdy1", 64'(src_ready[1]), 64'd0);
      end
    end
    src_valid = 4'b0000;
    tick();
    check("fp_last0", 64'(w_write_d_r), wr(1'b1, 6'd1, 32'hF000_0005));
    tick();
    check("fp_src1_a", 64'(w_write_d_r), wr(1'b1, 6'd2, 32'h2200_0000));
    tick();
    check("fp_src1_b", 64'(w_write_d_r), wr(1'b1, 6'd2, 32'h2200_0000));
    tick();
    check("fp_idle", 64'(w_write_d_r), 64'd0);
`endif

    // ---------------- flush of buffered entries ----------------
    do_reset();
    set_src(0, 6'd1, 32'h1111_0000, 4'b0000);
    set_src(1, 6'd2, 32'h2222_0000, 4'b0000);
    set_src(2, 6'd7, 32'h7777_0001, 4'b0001);
    src_valid = 4'b0111;
    tick();                                   // edge1: three accepts
    src_valid = 4'b0100;
    set_src(2, 6'd8, 32'h8888_0002, 4'b0010);
    tick();                                   // edge2: src2 now holds 01,10
    src_valid = 4'b0000;
    check("hz_e2", 64'(w_write_d_r), wr(1'b1, 6'd1, 32'h1111_0000));
    check("hz_rdy_full", 64'(src_ready[2]), 64'd0);
    tick();                                   // edge3: src1 on output
    branch_hazard       = 1'b1;
    hazard_context_info = 4'b0001;
    set_src(3, 6'd10, 32'hBAD0_0003, 4'b0001); // squashed on input
    src_valid = 4'b1000;
    #1;
    check("hz_e3", 64'(w_write_d_r), wr(1'b1, 6'd2, 32'h2222_0000));
    check("hz_drop_rdy", 64'(src_ready[3]), 64'd1);
    tick();                                   // edge4: ctx 01 entry flushed
    branch_hazard       = 1'b0;
    hazard_context_info = 4'b0000;
    src_valid           = 4'b0000;
    check("hz_e4", 64'(w_write_d_r), 64'd0);
    check("hz_rdy_after", 64'(src_ready[2]), 64'd1);
    tick();
    check("hz_e5", 64'(w_write_d_r), wr(1'b1, 6'd8, 32'h8888_0002));
    tick();
    check("hz_e6", 64'(w_write_d_r), 64'd0);
    tick();
    check("hz_e7", 64'(w_write_d_r), 64'd0);

    // ---------------- squash of the output register ----------------
    do_reset();
    set_src(0, 6'd9, 32'h9999_0009, 4'b0100);
    src_valid = 4'b0001;
    tick();
    src_valid = 4'b0000;
    tick();
    check("sq_pre", 64'(w_write_d_r), wr(1'b1, 6'd9, 32'h9999_0009));
    branch_hazard       = 1'b1;
    hazard_context_info = 4'b0100;
    #1;
    lg = {4'b0000, w_write_d_r[38]};
    check("sq_order", 64'(lg), 64'd0);
    tick();
    branch_hazard       = 1'b0;
    hazard_context_info = 4'b0000;
    check("sq_after", 64'(w_write_d_r), 64'd0);

    // ---------------- write to pa 0 is swallowed ----------------
    do_reset();
    set_src(3, 6'd0, 32'h0000_1234, 4'b0000);
    src_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("pa0_rdy", 64'(src_ready[3]), 64'd1);
      check("pa0_w", 64'(w_write_d_r), 64'd0);
    end
    src_valid = 4'b0000;
    tick();
    check("pa0_drain", 64'(w_write_d_r), 64'd0);

    // ---------------- reset with 5 buffered entries ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_src(i, 6'(i + 1), 32'h5500_0000 | 32'(i), 4'b0000);
    end
    src_valid = 4'b1111;
    tick();
    src_valid = 4'b0110;
    tick();
    rst       = 1'b1;
    src_valid = 4'b0000;
    tick();
    rst = 1'b0;
    check("rst_mid_w", 64'(w_write_d_r), 64'd0);
    check("rst_mid_rdy", 64'(src_ready), 64'hF);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_mid_idle", 64'(w_write_d_r), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
